// File: rtl/cve2_clear_sequencer.sv
// Drives the isolator's clear_n: drains outstanding OBI traffic on a host reset/hold
// request, then holds the core cleared for a fixed time or while hold is requested.
module cve2_clear_sequencer #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int HOLD_CYCLES     = 4,
  parameter int DRAIN_TIMEOUT   = 256,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          core_reset_i,
  input  logic          core_hold_i,
  input  logic          instr_req_i,
  input  logic          instr_gnt_i,
  input  logic          instr_rvalid_i,
  input  logic          data_req_i,
  input  logic          data_gnt_i,
  input  logic          data_rvalid_i,
  output logic          clear_n_o,
  output logic          busy_o,
  output logic          cleared_o,
  output logic          timeout_o,
  output logic [CW-1:0] instr_outstanding_o,
  output logic [CW-1:0] data_outstanding_o
);

  localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TW = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  state_e        r_state;
  logic [TW-1:0] r_timer;
  logic [HW-1:0] r_hold;
  logic [CW-1:0] r_instr_cnt;
  logic [CW-1:0] r_data_cnt;
  logic          r_clear_n;
  logic          r_busy;
  logic          r_cleared;
  logic          r_timeout;

  logic          w_instr_gnt;
  logic          w_data_gnt;
  logic          w_drained;
  logic [CW-1:0] w_instr_cnt_nxt;
  logic [CW-1:0] w_data_cnt_nxt;

  // Saturating up/down count; a simultaneous grant and response cancel out.
  function automatic logic [CW-1:0] f_next_count(input logic [CW-1:0] cnt,
                                                 input logic          inc,
                                                 input logic          dec);
    logic [CW-1:0] nxt;
    nxt = cnt;
    if (inc && !dec) begin
      if (cnt != CNT_MAX) nxt = cnt + CW'(1);
    end else if (dec && !inc) begin
      if (cnt != '0) nxt = cnt - CW'(1);
    end
    return nxt;
  endfunction

  assign w_instr_gnt     = instr_req_i & instr_gnt_i;
  assign w_data_gnt      = data_req_i & data_gnt_i;
  assign w_instr_cnt_nxt = f_next_count(r_instr_cnt, w_instr_gnt, instr_rvalid_i);
  assign w_data_cnt_nxt  = f_next_count(r_data_cnt, w_data_gnt, data_rvalid_i);

  // A grant this cycle opens a new transaction, so it blocks the drain just like a count.
  assign w_drained = (r_instr_cnt == '0) && (r_data_cnt == '0) && !w_instr_gnt && !w_data_gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_hold      <= '0;
      r_instr_cnt <= '0;
      r_data_cnt  <= '0;
      r_clear_n   <= 1'b1;
      r_busy      <= 1'b0;
      r_cleared   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout   <= 1'b0;
      r_instr_cnt <= w_instr_cnt_nxt;
      r_data_cnt  <= w_data_cnt_nxt;
      case (r_state)
        ST_IDLE: begin
          if (core_reset_i || core_hold_i) begin
            r_state <= ST_DRAIN;
            r_timer <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          r_timer <= r_timer + TW'(1);
          if (w_drained) begin
            r_state   <= ST_CLEAR;
            r_hold    <= HOLD_LAST;
            r_clear_n <= 1'b0;
            r_cleared <= 1'b1;
          end else if (r_timer == TIMER_LAST) begin
            // Abandoned transactions will never complete once the core is cleared.
            r_state     <= ST_CLEAR;
            r_hold      <= HOLD_LAST;
            r_clear_n   <= 1'b0;
            r_cleared   <= 1'b1;
            r_timeout   <= 1'b1;
            r_instr_cnt <= '0;
            r_data_cnt  <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_hold != '0) begin
            r_hold <= r_hold - HW'(1);
          end else if (!core_hold_i) begin
            r_state   <= ST_IDLE;
            r_clear_n <= 1'b1;
            r_cleared <= 1'b0;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_clear_n <= 1'b1;
          r_cleared <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign clear_n_o           = r_clear_n;
  assign busy_o              = r_busy;
  assign cleared_o           = r_cleared;
  assign timeout_o           = r_timeout;
  assign instr_outstanding_o = r_instr_cnt;
  assign data_outstanding_o  = r_data_cnt;

endmodule
